// File: rtl/mac_divider.sv
// mac_divider: sequential restoring divider, MUL_WIDTH-bit dividend by a
// DATA_WIDTH-bit divisor, one quotient bit per clock, with valid/ready
// handshakes on both sides. Divide-by-zero and quotient overflow are
// resolved on the accepting edge without iterating.
// Optional build macro: MAC_DIVIDER_DISPLAY_EN prints each result as it
// becomes valid; behaviour and timing are unchanged either way.
// MUL_WIDTH is expected to equal 2*DATA_WIDTH.
module mac_divider #(
    parameter int DATA_WIDTH = 16,
    parameter int MUL_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MUL_WIDTH-1:0]  dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;      // partial remainder; stays below the divisor
    logic [DATA_WIDTH-1:0] q_q, q_d;      // low dividend bits shifting out, quotient bits in
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] dvd_hi, dvd_lo;
    logic [DATA_WIDTH:0]   r_shift;       // R shifted left with the next dividend bit: one extra bit
    logic                  fits;

    assign dvd_hi = dividend[MUL_WIDTH-1:DATA_WIDTH];
    assign dvd_lo = dividend[DATA_WIDTH-1:0];

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    // Next-state and datapath: accept/classify in IDLE, one restoring step per CALC cycle.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        r_shift = {r_q, q_q[DATA_WIDTH-1]};
        fits    = (r_shift >= {1'b0, div_q});

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quo_d   = '1;
                        rem_d   = dvd_lo;
                    end else if (dvd_hi >= divisor) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = S_CALC;
                        r_d     = dvd_hi;
                        q_d     = dvd_lo;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            S_CALC: begin
                // The difference always fits DATA_WIDTH bits because it is below the divisor.
                r_d   = fits ? (r_shift[DATA_WIDTH-1:0] - div_q) : r_shift[DATA_WIDTH-1:0];
                q_d   = {q_q[DATA_WIDTH-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    quo_d   = q_d;
                    rem_d   = r_d;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MAC_DIVIDER_DISPLAY_EN
    logic [MUL_WIDTH-1:0] dividend_q;
    logic [MUL_WIDTH-1:0] disp_dividend;

    // Special cases finish on the accepting edge, before the dividend is registered.
    assign disp_dividend = (state_q == S_IDLE) ? dividend : dividend_q;

    // Keep the accepted dividend for the report printed when the result is ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend_q <= '0;
        end else if (state_q == S_IDLE && in_valid) begin
            dividend_q <= dividend;
        end
    end

    // Report each result on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst && state_q != S_DONE && state_d == S_DONE) begin
            $display("mac_divider: dividend=%0d divisor=%0d quotient=%0d remainder=%0d div_by_zero=%0b overflow=%0b",
                     disp_dividend, div_d, quo_d, rem_d, dbz_d, ovf_d);
        end
    end
`endif

endmodule

// File: tb/tb_mac_divider.sv
// tb_mac_divider: randomized self-checking bench for mac_divider with an
// arithmetic reference model (plain / and %).
module tb_mac_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    mac_divider #(.DATA_WIDTH(16), .MUL_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: ordinary unsigned division with the special-case rules.
    function automatic void model(input logic [31:0] dd, input logic [15:0] dv,
                                  output logic [15:0] eq, output logic [15:0] er,
                                  output logic ez, output logic eo);
        longint unsigned qq;
        ez = 1'b0;
        eo = 1'b0;
        if (dv == 16'd0) begin
            ez = 1'b1;
            eq = 16'hFFFF;
            er = dd[15:0];
        end else begin
            qq = longint'(dd) / longint'(dv);
            if (qq > 64'hFFFF) begin
                eo = 1'b1;
                eq = 16'hFFFF;
                er = 16'h0000;
            end else begin
                eq = 16'(qq);
                er = 16'(longint'(dd) % longint'(dv));
            end
        end
    endfunction

    // One complete operation: accept, wait for the result while poking in_valid,
    // optionally stall the consumer for 'hold' cycles, then complete the handshake.
    // Latency is the number of edges after the accepting edge until out_valid.
    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, input int hold);
        logic [15:0] eq, er;
        logic        ez, eo;
        int          exp_lat;
        int          edges;
        model(dd, dv, eq, er, ez, eo);
        exp_lat = (ez || eo) ? 0 : 16;

        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        dividend  = dd;
        divisor   = dv;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        edges = 0;
        while (!out_valid && edges < 200) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor  = 16'($urandom);
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;

        check("latency", 32'(edges), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(ez));
        check("overflow", 32'(overflow), 32'(eo));
        check("in_ready_done", 32'(in_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = 16'd1;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_quotient", 32'(quotient), 32'(eq));
            check("hold_remainder", 32'(remainder), 32'(er));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("after_hs_valid", 32'(out_valid), 32'd0);
        check("after_hs_in_ready", 32'(in_ready), 32'd1);
        check("after_hs_quotient_kept", 32'(quotient), 32'(eq));
    endtask

    initial begin
        logic [15:0] dv;
        logic [31:0] dd;
        int          kind;

        // Reset state
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_flags", 32'({div_by_zero, overflow}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op(32'd100, 16'd7, 0);
        run_op(32'hFFFE0001, 16'hFFFF, 0);
        run_op(32'd1234, 16'd0, 0);
        run_op(32'h00010000, 16'd1, 0);
        run_op(32'h0000ABCD, 16'd1, 0);
        run_op(32'd0, 16'd9, 0);
        run_op(32'd1000, 16'd3, 5);

        // Reset in the middle of CALC
        dividend  = 32'd100;
        divisor   = 16'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
        check("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
        check("midcalc_rst_quotient", 32'(quotient), 32'd0);
        check("midcalc_rst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("midcalc_rel_in_ready", 32'(in_ready), 32'd1);
        check("midcalc_rel_out_valid", 32'(out_valid), 32'd0);
        run_op(32'd50, 16'd5, 0);

        // Reset while holding a result in DONE
        dividend  = 32'd77;
        divisor   = 16'd0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("done_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("done_rst_out_valid", 32'(out_valid), 32'd0);
        check("done_rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            dv   = 16'($urandom);
            if (dv == 16'd0) dv = 16'd1;
            if (kind == 0) begin
                dv = 16'd0;
                dd = $urandom;
            end else if (kind == 1) begin
                dd = {16'($urandom_range(32'(dv), 32'hFFFF)), 16'($urandom)};
            end else begin
                if (kind == 2) dv = 16'($urandom_range(1, 15));
                dd = 32'(longint'($urandom) % (longint'(dv) << 16));
            end
            run_op(dd, dv, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
